// File: rtl/requant_pkg.sv
// Shared widths, the S1/S2 payload record and the output clamp used by requant_stage.
package requant_pkg;

    localparam int unsigned REQ_ACC_W   = 32;
    localparam int unsigned REQ_MULT_W  = 16;
    localparam int unsigned REQ_SHIFT_W = 5;
    localparam int unsigned REQ_OUT_W   = 8;
    localparam int unsigned REQ_CNT_W   = 16;
    localparam int unsigned REQ_PROD_W  = REQ_ACC_W + REQ_MULT_W + 1;
    localparam int unsigned REQ_SUM_W   = REQ_PROD_W + 1;

    // val holds the product in S1 and the rounded value in S2
    typedef struct packed {
        logic signed [REQ_PROD_W-1:0] val;
        logic [REQ_SHIFT_W-1:0]       shift;
        logic signed [REQ_OUT_W-1:0]  zp;
        logic                         last;
    } requant_payload_t;

    function automatic logic signed [REQ_SUM_W-1:0] sat_clamp(
        input logic signed [REQ_SUM_W-1:0] value,
        input int unsigned                 out_w
    );
        logic signed [REQ_SUM_W-1:0] hi;
        logic signed [REQ_SUM_W-1:0] lo;
        hi = (REQ_SUM_W'(1) << (out_w - 1)) - REQ_SUM_W'(1);
        lo = ~hi;
        if (value > hi) begin
            return hi;
        end else if (value < lo) begin
            return lo;
        end
        return value;
    endfunction

endpackage

// File: rtl/requant_round_shift.sv
// Combinational arithmetic right shift with round-half-up (toward +inf).
module requant_round_shift #(
    parameter int unsigned W       = 49,
    parameter int unsigned SHIFT_W = 5
) (
    input  logic signed [W-1:0]   value,
    input  logic [SHIFT_W-1:0]    shift,
    output logic signed [W-1:0]   result
);

    logic signed [W:0] biased;
    logic signed [W:0] shifted;

    // One guard bit so the half-LSB bias can never wrap the sign.
    always_comb begin
        biased = {value[W-1], value};
        if (shift != '0) begin
            biased = biased + ((W+1)'(1) << (shift - SHIFT_W'(1)));
        end
        shifted = biased >>> shift;
        result  = shifted[W-1:0];
    end

endmodule

// File: rtl/requant_stage.sv
// Three-stage requantizer: scale multiply, rounding shift, zero-point add and saturate.
module requant_stage
    import requant_pkg::*;
#(
    parameter int unsigned ACC_W   = REQ_ACC_W,
    parameter int unsigned MULT_W  = REQ_MULT_W,
    parameter int unsigned SHIFT_W = REQ_SHIFT_W,
    parameter int unsigned OUT_W   = REQ_OUT_W,
    parameter int unsigned CNT_W   = REQ_CNT_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cfg_we,
    input  logic [MULT_W-1:0]        cfg_mult,
    input  logic [SHIFT_W-1:0]       cfg_shift,
    input  logic signed [OUT_W-1:0]  cfg_zp,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [ACC_W-1:0]  in_data,
    input  logic                     in_last,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [OUT_W-1:0]  out_data,
    output logic                     out_last,
    output logic [CNT_W-1:0]         sat_cnt
);

    localparam int unsigned PROD_W = ACC_W + MULT_W + 1;
    localparam int unsigned SUM_W  = PROD_W + 1;

    logic [MULT_W-1:0]        mult_q;
    logic [SHIFT_W-1:0]       shift_q;
    logic signed [OUT_W-1:0]  zp_q;

    logic                     adv;
    logic                     s1_valid;
    logic                     s2_valid;
    logic                     s3_valid;
    logic                     s3_sat;
    requant_payload_t         s1;
    requant_payload_t         s2;

    logic signed [PROD_W-1:0] prod;
    logic signed [PROD_W-1:0] rnd;
    logic signed [SUM_W-1:0]  sum;
    logic signed [SUM_W-1:0]  clamped;
    logic                     unused_s2_shift;

    assign adv       = out_ready | ~s3_valid;
    assign in_ready  = adv;
    assign out_valid = s3_valid;

    assign prod    = PROD_W'($signed(in_data)) * PROD_W'($signed({1'b0, mult_q}));
    assign sum     = SUM_W'(s2.val) + SUM_W'(s2.zp);
    assign clamped = sat_clamp(sum, OUT_W);

    // Shift is consumed in S2; the S2 copy only keeps the payload record uniform.
    assign unused_s2_shift = ^s2.shift;

    requant_round_shift #(
        .W       (PROD_W),
        .SHIFT_W (SHIFT_W)
    ) u_round (
        .value  (s1.val),
        .shift  (s1.shift),
        .result (rnd)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mult_q  <= MULT_W'(1);
            shift_q <= '0;
            zp_q    <= '0;
        end else if (cfg_we) begin
            mult_q  <= cfg_mult;
            shift_q <= cfg_shift;
            zp_q    <= cfg_zp;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            s3_valid <= 1'b0;
            s1       <= '0;
            s2       <= '0;
            s3_sat   <= 1'b0;
            out_data <= '0;
            out_last <= 1'b0;
        end else if (adv) begin
            s1_valid <= in_valid;
            s1       <= '{val: prod, shift: shift_q, zp: zp_q, last: in_last};
            s2_valid <= s1_valid;
            s2       <= '{val: rnd, shift: s1.shift, zp: s1.zp, last: s1.last};
            s3_valid <= s2_valid;
            out_data <= clamped[OUT_W-1:0];
            out_last <= s2.last;
            s3_sat   <= (clamped != sum);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_cnt <= '0;
        end else if (cfg_we) begin
            sat_cnt <= '0;
        end else if (s3_valid && out_ready && s3_sat && (sat_cnt != '1)) begin
            sat_cnt <= sat_cnt + CNT_W'(1);
        end
    end

endmodule
